// File: rtl/rhd_resp_pkg.sv
// Shared constants, types and small helpers for the RHD2000 command responder.
package rhd_resp_pkg;

    localparam int SYNC_DEPTH = 2;
    localparam int RAM_DEPTH  = 22;

    localparam logic [1:0] OP_CONVERT = 2'b00;
    localparam logic [1:0] OP_MISC    = 2'b01;
    localparam logic [1:0] OP_WRITE   = 2'b10;
    localparam logic [1:0] OP_READ    = 2'b11;

    localparam logic [15:0] CMD_CALIBRATE = 16'h5500;
    localparam logic [15:0] CMD_CLEAR     = 16'h6A00;

    localparam logic [5:0] ADDR_ROM_I      = 6'd40;
    localparam logic [5:0] ADDR_ROM_N0     = 6'd41;
    localparam logic [5:0] ADDR_ROM_T      = 6'd42;
    localparam logic [5:0] ADDR_ROM_A      = 6'd43;
    localparam logic [5:0] ADDR_ROM_N1     = 6'd44;
    localparam logic [5:0] ADDR_DIE_REV    = 6'd60;
    localparam logic [5:0] ADDR_UNIPOLAR   = 6'd61;
    localparam logic [5:0] ADDR_NUM_AMPS   = 6'd62;
    localparam logic [5:0] ADDR_CHIP_ID    = 6'd63;

    localparam logic [7:0] VAL_ROM_I       = 8'h49;
    localparam logic [7:0] VAL_ROM_N       = 8'h4E;
    localparam logic [7:0] VAL_ROM_T       = 8'h54;
    localparam logic [7:0] VAL_ROM_A       = 8'h41;
    localparam logic [7:0] VAL_DIE_REV     = 8'h00;
    localparam logic [7:0] VAL_UNIPOLAR    = 8'h01;
    localparam logic [7:0] VAL_NUM_AMPS    = 8'h40;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FULL   = 2'd2,
        ST_OVER   = 2'd3
    } resp_state_e;

    function automatic logic is_ram_addr(input logic [5:0] addr);
        return (int'(addr) < RAM_DEPTH);
    endfunction

    function automatic logic [4:0] cnt_sat_inc(input logic [4:0] cnt);
        if (cnt == 5'd31) begin
            return cnt;
        end else begin
            return cnt + 5'd1;
        end
    endfunction

    function automatic resp_state_e state_for_cnt(input logic [4:0] cnt);
        if (cnt < 5'd16) begin
            return ST_ACTIVE;
        end else if (cnt == 5'd16) begin
            return ST_FULL;
        end else begin
            return ST_OVER;
        end
    endfunction

endpackage

// File: rtl/rhd_resp_regfile.sv
// 22x8 writable register RAM plus read-only ID registers, with write-to-read bypass.
module rhd_resp_regfile
    import rhd_resp_pkg::*;
#(
    parameter logic [7:0] CHIP_ID = 8'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [5:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [5:0] rd_addr,
    output logic [7:0] rd_data
);

    logic [7:0] ram_q [0:RAM_DEPTH-1];
    logic [7:0] ram_d [0:RAM_DEPTH-1];

    // Next RAM contents: writes outside the RAM range are dropped.
    always_comb begin
        ram_d = ram_q;
        if (wr_en && is_ram_addr(wr_addr)) begin
            ram_d[wr_addr[4:0]] = wr_data;
        end else begin
            ram_d = ram_q;
        end
    end

    // RAM storage with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RAM_DEPTH; i++) begin
                ram_q[i] <= 8'h00;
            end
        end else begin
            ram_q <= ram_d;
        end
    end

    // Read mux: RAM (bypassing a same-cycle write) or fixed ID registers.
    always_comb begin
        rd_data = 8'h00;
        if (is_ram_addr(rd_addr)) begin
            if (wr_en && (wr_addr == rd_addr)) begin
                rd_data = wr_data;
            end else begin
                rd_data = ram_q[rd_addr[4:0]];
            end
        end else begin
            case (rd_addr)
                ADDR_ROM_I:    rd_data = VAL_ROM_I;
                ADDR_ROM_N0:   rd_data = VAL_ROM_N;
                ADDR_ROM_T:    rd_data = VAL_ROM_T;
                ADDR_ROM_A:    rd_data = VAL_ROM_A;
                ADDR_ROM_N1:   rd_data = VAL_ROM_N;
                ADDR_DIE_REV:  rd_data = VAL_DIE_REV;
                ADDR_UNIPOLAR: rd_data = VAL_UNIPOLAR;
                ADDR_NUM_AMPS: rd_data = VAL_NUM_AMPS;
                ADDR_CHIP_ID:  rd_data = CHIP_ID;
                default:       rd_data = 8'h00;
            endcase
        end
    end

endmodule

// File: rtl/rhd_cmd_responder.sv
// RHD2000 SPI chip-side responder with a two-frame result pipeline on MISO.
// Optional CONVERT frame counter is enabled by defining RHD_RESP_FRAME_CNT_EN.
module rhd_cmd_responder
    import rhd_resp_pkg::*;
#(
    parameter int STARTING_SEED = 0,
    parameter int CHIP_ID       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CS,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        cmd_valid,
    output logic [15:0] cmd_word,
    output logic        frame_err
);

    localparam logic [15:0] SEED16   = STARTING_SEED[15:0];
    localparam logic [7:0]  CHIP_ID8 = CHIP_ID[7:0];

    logic [SYNC_DEPTH-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_DEPTH-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_DEPTH-1:0] mosi_sync_q, mosi_sync_d;
    logic                  cs_dly_q, cs_dly_d;
    logic                  sclk_dly_q, sclk_dly_d;
    logic                  armed_q, armed_d;
    resp_state_e           state_q, state_d;
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    logic [15:0]           cmd_q, cmd_d;
    logic [15:0]           shift_q, shift_d;
    logic                  miso_q, miso_d;
    logic [15:0]           stage1_q, stage1_d;
    logic [15:0]           stage2_q, stage2_d;
    logic [15:0]           cmd_word_q, cmd_word_d;
    logic                  cmd_valid_q, cmd_valid_d;
    logic                  frame_err_q, frame_err_d;

    logic        cs_s, sclk_s, mosi_s;
    logic        cs_fall_s, cs_rise_s, sclk_rise_s, sclk_fall_s;
    logic        commit_s, wr_en_s;
    logic [7:0]  rd_data_s;
    logic [15:0] result_s, conv_offset_s;

    assign cs_s   = cs_sync_q[SYNC_DEPTH-1];
    assign sclk_s = sclk_sync_q[SYNC_DEPTH-1];
    assign mosi_s = mosi_sync_q[SYNC_DEPTH-1];

    // A CS fall only counts once CS has been seen high since reset.
    assign cs_fall_s   = armed_q & cs_dly_q & ~cs_s;
    assign cs_rise_s   = ~cs_dly_q & cs_s;
    assign sclk_rise_s = ~sclk_dly_q & sclk_s;
    assign sclk_fall_s = sclk_dly_q & ~sclk_s;

    assign wr_en_s = commit_s & (cmd_q[15:14] == OP_WRITE);

    rhd_resp_regfile #(
        .CHIP_ID (CHIP_ID8)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en_s),
        .wr_addr (cmd_q[13:8]),
        .wr_data (cmd_q[7:0]),
        .rd_addr (cmd_q[13:8]),
        .rd_data (rd_data_s)
    );

`ifdef RHD_RESP_FRAME_CNT_EN
    logic [9:0] frame_cnt_q, frame_cnt_d;

    // Count committed CONVERTs of channel 63 (wraps naturally at 10 bits).
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (commit_s && (cmd_q[15:14] == OP_CONVERT) && (cmd_q[13:8] == 6'd63)) begin
            frame_cnt_d = frame_cnt_q + 10'd1;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Frame counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= 10'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign conv_offset_s = {frame_cnt_q, 6'd0};
`else
    assign conv_offset_s = 16'h0000;
`endif

    // Command decode; CALIBRATE, CLEAR and unknown 01 patterns all return zero.
    always_comb begin
        result_s = 16'h0000;
        case (cmd_q[15:14])
            OP_CONVERT: result_s = SEED16 + {10'd0, cmd_q[13:8]} + conv_offset_s;
            OP_WRITE:   result_s = {8'hFF, cmd_q[7:0]};
            OP_READ:    result_s = {8'h00, rd_data_s};
            default: begin
                case (cmd_q)
                    CMD_CALIBRATE: result_s = 16'h0000;
                    CMD_CLEAR:     result_s = 16'h0000;
                    default:       result_s = 16'h0000;
                endcase
            end
        endcase
    end

    // Frame FSM: bit capture, MISO shifting, and commit/abort on CS rise.
    always_comb begin
        cs_sync_d   = {cs_sync_q[SYNC_DEPTH-2:0], CS};
        sclk_sync_d = {sclk_sync_q[SYNC_DEPTH-2:0], SCLK};
        mosi_sync_d = {mosi_sync_q[SYNC_DEPTH-2:0], MOSI};
        cs_dly_d    = cs_s;
        sclk_dly_d  = sclk_s;
        armed_d     = armed_q | cs_s;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        cmd_d       = cmd_q;
        shift_d     = shift_q;
        miso_d      = miso_q;
        stage1_d    = stage1_q;
        stage2_d    = stage2_q;
        cmd_word_d  = cmd_word_q;
        cmd_valid_d = 1'b0;
        frame_err_d = 1'b0;
        commit_s    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall_s) begin
                    state_d   = ST_ACTIVE;
                    bit_cnt_d = 5'd0;
                    cmd_d     = 16'h0000;
                    shift_d   = stage2_q;
                    miso_d    = stage2_q[15];
                end else begin
                    miso_d = 1'b0;
                end
            end
            ST_ACTIVE, ST_FULL, ST_OVER: begin
                // CS rise takes priority over a coincident SCLK edge.
                if (cs_rise_s) begin
                    state_d = ST_IDLE;
                    miso_d  = 1'b0;
                    shift_d = 16'h0000;
                    if (state_q == ST_FULL) begin
                        commit_s    = 1'b1;
                        stage2_d    = stage1_q;
                        stage1_d    = result_s;
                        cmd_word_d  = cmd_q;
                        cmd_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else if (sclk_rise_s) begin
                    cmd_d     = {cmd_q[14:0], mosi_s};
                    bit_cnt_d = cnt_sat_inc(bit_cnt_q);
                    state_d   = state_for_cnt(cnt_sat_inc(bit_cnt_q));
                end else if (sclk_fall_s) begin
                    shift_d = {shift_q[14:0], 1'b0};
                    miso_d  = shift_q[14];
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                miso_d  = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync_q   <= '0;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_dly_q    <= 1'b0;
            sclk_dly_q  <= 1'b0;
            armed_q     <= 1'b0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 5'd0;
            cmd_q       <= 16'h0000;
            shift_q     <= 16'h0000;
            miso_q      <= 1'b0;
            stage1_q    <= 16'h0000;
            stage2_q    <= 16'h0000;
            cmd_word_q  <= 16'h0000;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            cs_sync_q   <= cs_sync_d;
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cs_dly_q    <= cs_dly_d;
            sclk_dly_q  <= sclk_dly_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            cmd_q       <= cmd_d;
            shift_q     <= shift_d;
            miso_q      <= miso_d;
            stage1_q    <= stage1_d;
            stage2_q    <= stage2_d;
            cmd_word_q  <= cmd_word_d;
            cmd_valid_q <= cmd_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign MISO      = miso_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_word  = cmd_word_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_rhd_cmd_responder.sv
// Scoreboard bench for rhd_cmd_responder: SPI master driver, result-history model, MISO and pulse monitors.
module tb_rhd_cmd_responder;

    localparam int SEED = 64;
    localparam int CHIP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        CS;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic        cmd_valid;
    logic [15:0] cmd_word;
    logic        frame_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        is_valid;
        logic [15:0] cmd;
    } ev_t;

    ev_t         exp_ev[$];
    logic [15:0] exp_miso[$];

    logic [7:0]  m_regs [22];
    logic [15:0] m_hist[$];
    logic [15:0] m_last_cmd;
    int          m_fcnt;

    rhd_cmd_responder #(
        .STARTING_SEED (SEED),
        .CHIP_ID       (CHIP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .CS        (CS),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .cmd_valid (cmd_valid),
        .cmd_word  (cmd_word),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic missing(input string name);
        total++;
        bad++;
        $display("FAIL %s: DUT produced output but no expectation was queued", name);
    endtask

    // Reference: register contents as the chip documents them.
    function automatic logic [7:0] m_read(input int r);
        if (r < 22) return m_regs[r];
        case (r)
            40: return 8'h49;
            41: return 8'h4E;
            42: return 8'h54;
            43: return 8'h41;
            44: return 8'h4E;
            60: return 8'h00;
            61: return 8'h01;
            62: return 8'h40;
            63: return 8'(CHIP);
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [15:0] m_result(input logic [15:0] w);
        int op;
        int r;
        op = int'(w[15:14]);
        r  = int'(w[13:8]);
        case (op)
            0:       return 16'(SEED + r + m_fcnt * 64);
            2:       return {8'hFF, w[7:0]};
            3:       return {8'h00, m_read(r)};
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 22; i++) m_regs[i] = 8'h00;
        m_hist.delete();
        m_last_cmd = 16'h0000;
        m_fcnt = 0;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic shift_bits(input logic [15:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            MOSI = (i < 16) ? w[15-i] : 1'($urandom);
            wait_clk(6);
            SCLK = 1'b1;
            wait_clk(6);
            SCLK = 1'b0;
        end
    endtask

    // Update the model and queue expectations, then drive one frame.
    task automatic send_frame(input logic [15:0] w, input int nbits);
        ev_t e;
        int  idx;
        if (nbits == 16) begin
            exp_miso.push_back((m_hist.size() >= 2) ? m_hist[m_hist.size()-2] : 16'h0000);
            m_hist.push_back(m_result(w));
            idx = int'(w[13:8]);
            if (w[15:14] == 2'b10 && idx < 22) m_regs[idx] = w[7:0];
`ifdef RHD_RESP_FRAME_CNT_EN
            if (w[15:14] == 2'b00 && idx == 63) m_fcnt = (m_fcnt + 1) % 1024;
`endif
            m_last_cmd = w;
            e.is_valid = 1'b1;
            e.cmd = w;
        end else begin
            e.is_valid = 1'b0;
            e.cmd = m_last_cmd;
        end
        exp_ev.push_back(e);
        CS = 1'b0;
        wait_clk(6);
        shift_bits(w, nbits);
        wait_clk(6);
        CS = 1'b1;
        wait_clk(10);
    endtask

    function automatic logic [15:0] rand_cmd();
        int sel;
        sel = $urandom_range(0, 5);
        case (sel)
            0: return {2'b00, 6'($urandom), 8'($urandom)};
            1: return {2'b10, 6'($urandom_range(0, 31)), 8'($urandom)};
            2: return {2'b11, 6'($urandom_range(0, 21)), 8'($urandom)};
            3: return {2'b11, 6'($urandom), 8'($urandom)};
            4: return ($urandom_range(0, 1) == 0) ? 16'h5500 : 16'h6A00;
            default: return {2'b01, 14'($urandom)};
        endcase
    endfunction

    // MISO monitor: assemble the word the master sees on each SCLK rise.
    initial begin
        int          cnt;
        logic [15:0] word;
        cnt = 0;
        word = 16'h0000;
        forever begin
            @(negedge CS or posedge SCLK or posedge CS);
            if (CS === 1'b1) begin
                if (cnt == 16) begin
                    if (exp_miso.size() == 0) missing("miso_word");
                    else check("miso_word", word, exp_miso.pop_front());
                end
                cnt = 0;
            end else if (SCLK === 1'b1) begin
                word = {word[14:0], MISO};
                cnt++;
            end else begin
                cnt = 0;
                word = 16'h0000;
            end
        end
    end

    // Pulse monitor: every cmd_valid/frame_err pulse must match a queued frame outcome.
    always @(negedge clk) begin
        ev_t e;
        if (cmd_valid === 1'b1 || frame_err === 1'b1) begin
            if (exp_ev.size() == 0) begin
                missing("pulse");
            end else begin
                e = exp_ev.pop_front();
                check("cmd_valid_kind", {15'd0, cmd_valid}, {15'd0, e.is_valid});
                check("frame_err_kind", {15'd0, frame_err}, {15'd0, ~e.is_valid});
                check("cmd_word", cmd_word, e.cmd);
            end
        end
    end

    initial begin
        int nb;
        rst  = 1'b1;
        CS   = 1'b1;
        SCLK = 1'b0;
        MOSI = 1'b0;
        model_reset();
        wait_clk(5);
        rst = 1'b0;
        wait_clk(3);
        check("reset_miso", {15'd0, MISO}, 16'h0000);
        check("reset_cmd_valid", {15'd0, cmd_valid}, 16'h0000);
        check("reset_frame_err", {15'd0, frame_err}, 16'h0000);
        check("reset_cmd_word", cmd_word, 16'h0000);

        send_frame(16'h0500, 16);
        send_frame(16'hC000, 16);
        send_frame(16'hC000, 16);

        send_frame(16'h83A5, 16);
        send_frame(16'hC300, 16);
        send_frame(16'hC000, 16);
        send_frame(16'hC000, 16);
        send_frame(16'hD600, 16);
        send_frame(16'hC000, 16);
        send_frame(16'hC000, 16);

        for (int r = 40; r <= 44; r++) send_frame({2'b11, 6'(r), 8'h00}, 16);
        send_frame(16'hFF00, 16);
        send_frame(16'hC000, 16);
        send_frame(16'hC000, 16);
        check("miso_idle", {15'd0, MISO}, 16'h0000);

        send_frame(16'h8155, 12);
        send_frame(16'h8155, 17);
        send_frame(16'hC100, 16);
        send_frame(16'hC000, 16);
        send_frame(16'hC000, 16);

        // Reset in the middle of a WRITE frame: nothing from it may survive.
        CS = 1'b0;
        wait_clk(6);
        shift_bits(16'h83A5, 8);
        rst = 1'b1;
        model_reset();
        wait_clk(3);
        rst = 1'b0;
        wait_clk(3);
        CS = 1'b1;
        wait_clk(10);
        check("rst_cmd_word", cmd_word, 16'h0000);
        send_frame(16'hC300, 16);
        send_frame(16'hC000, 16);
        send_frame(16'hC000, 16);

        for (int k = 0; k < 80; k++) begin
            nb = 16;
            if ($urandom_range(0, 7) == 0) begin
                nb = $urandom_range(10, 20);
                if (nb == 16) nb = 15;
            end
            send_frame(rand_cmd(), nb);
        end
        check("miso_idle_end", {15'd0, MISO}, 16'h0000);

        for (int t = 0; t < 100 && (exp_miso.size() != 0 || exp_ev.size() != 0); t++) wait_clk(1);
        check("exp_miso_left", 16'(exp_miso.size()), 16'h0000);
        check("exp_ev_left", 16'(exp_ev.size()), 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rhd_cmd_responder.md
# rhd_cmd_responder

Synthesizable RHD2000-family SPI responder: the chip-side end of the link driven by `rhd_2048`. It samples CS/SCLK/MOSI on the fabric clock, decodes 16-bit RHD2000 commands (CONVERT, CALIBRATE, CLEAR, WRITE, READ) and drives MISO with results delayed by the chip's two-command pipeline. It is used as an on-board loopback target and as a bench model that can be synthesized, one instance per MISO line.

## Interface
- `STARTING_SEED`, 0: base value for CONVERT results (16-bit, truncated).
- `CHIP_ID`, 4: value returned by ROM register 63.
- `clk`  in  1  fabric clock (112 MHz); all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `CS`  in  1  SPI chip select, active low; asynchronous to `clk`.
- `SCLK`  in  1  SPI clock, idle low; asynchronous to `clk`.
- `MOSI`  in  1  SPI data from the master.
- `MISO`  out  1  SPI data to the master.
- `cmd_valid`  out  1  one-cycle pulse when a 16-bit frame is committed.
- `cmd_word`  out  16  the last committed command; held until the next commit.
- `frame_err`  out  1  one-cycle pulse when a frame closes with a bit count other than 16.

## Operation
- CS, SCLK and MOSI each pass through a 2-flop synchronizer. A third flop on each gives edge detection.
- States:
  - IDLE: CS high.
  - ACTIVE: CS low, fewer than 16 bits received.
  - FULL: 16 bits received.
  - OVER: more than 16 bits received.
  - After reset, the block stays in IDLE until synchronized CS has been sampled high at least once.
- CS falling edge:
  - Go to ACTIVE and clear the bit count.
  - Load the MISO shifter with pipeline stage 2.
  - Drive MISO = shifter bit 15.
- SCLK rising edge (in ACTIVE/FULL/OVER): shift synchronized MOSI into the command register MSB-first and increment the 5-bit saturating bit count.
- SCLK falling edge: shift the MISO shifter left, filling with 0; MISO = new bit 15.
- CS rising edge:
  - Count == 16: decode and commit. Stage2 <= stage1, stage1 <= result. Pulse `cmd_valid`.
  - Any other count: pulse `frame_err`. Pipeline, registers and `cmd_word` are unchanged.
- Decode (C = channel, R = register, D = data):
  - `00CCCCCC xxxxxxxx` CONVERT: result = STARTING_SEED + C (16-bit wrap).
  - `01010101 00000000` CALIBRATE: result = 0x0000.
  - `01101010 00000000` CLEAR: result = 0x0000.
  - `10RRRRRR DDDDDDDD` WRITE: if R <= 21, reg[R] <= D. Result = {0xFF, D} regardless of R.
  - `11RRRRRR xxxxxxxx` READ: result = {0x00, rd(R)}.
  - Any other `01` pattern: result = 0x0000, no side effect.
- `rd(R)` sources:
  - R 0–21: RAM, reset value 0x00.
  - R 40–44: 0x49 0x4E 0x54 0x41 0x4E ("INTAN").
  - R 60: 0x00. R 61: 0x01. R 62: 0x40. R 63: CHIP_ID.
  - Any other R: 0x00.
- READ of a register written in the immediately preceding frame returns the new value.

## Timing
- Reset values: MISO 0, `cmd_valid` 0, `frame_err` 0, `cmd_word` 0x0000, both pipeline stages 0x0000, RAM 0x00, state IDLE.
- Pin edge to internal action: 3 `clk` cycles. A SCLK fall at the pin appears on MISO 3 cycles later; the master's oversample offset absorbs this.
- `cmd_valid`/`frame_err` assert 3 cycles after the CS rise at the pin. The register write lands on the same cycle.
- Result of frame n appears on MISO during frame n+2. The first two frames after reset return 0x0000.
- CS high: MISO = 0, not tristated. OVER: MISO stays 0 once the shifter is exhausted.
- CS rise and an SCLK edge in the same synchronized sample: CS wins and the SCLK edge is ignored.
- `rst` mid-frame: all state clears on the next edge. The partial frame is discarded without `frame_err`.
- Minimum SCLK high/low time: 3 `clk` periods.

## Configuration
- `RHD_RESP_FRAME_CNT_EN` defined:
  - An 10-bit frame counter increments on every committed CONVERT with C == 63, wrapping 1023 -> 0.
  - CONVERT result = STARTING_SEED + C + (frame_cnt << 6), 16-bit wrap.
  - Counter resets to 0.
- Not defined: the counter is absent and CONVERT results are constant per channel.

## Structure
- Package `rhd_resp_pkg` holds:
  - opcode constants (CONVERT 2'b00, WRITE 2'b10, READ 2'b11);
  - CALIBRATE/CLEAR full words;
  - ROM register addresses and values;
  - RAM depth 22;
  - synchronizer depth 2.
- Sub-module `rhd_resp_regfile` contains the 22x8 RAM, the ROM mux and the write-before-read bypass. Its ports are clk, rst, wr_en, wr_addr, wr_data, rd_addr, rd_data.

## Test plan
- STARTING_SEED = 64; frames 0x0500, 0xC000, 0xC000 -> MISO words 0x0000, 0x0000, 0x0045.
- WRITE 0x83A5, READ 0xC300, two dummy READs -> third and fourth words 0xFFA5, 0x00A5. READ 0xD600 (reg 22) -> 0x0000.
- READ regs 40–44 and 63, plus 2 padding frames -> 0x0049, 0x004E, 0x0054, 0x0041, 0x004E, 0x0004.
- 12-bit frame, then 17-bit frame -> two `frame_err` pulses, no `cmd_valid`; pipeline output unchanged on the next valid frames.
- `rst` asserted after 8 bits of 0x83A5 -> no write; reg 3 reads 0x00; first two results 0x0000.
- With `RHD_RESP_FRAME_CNT_EN`, seed 0: CONVERT ch 63, then ch 0 -> results 0x003F, 0x0040.
